// File: rtl/console_writer.sv
// console_writer: text console front end. Accepts command bytes, keeps a shadow
// copy of the character grid and emits cell writes (character, cursor glyph,
// restores and full-screen clears) onto a simple display buffer bus.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a command; ready=1
// WR1   | write/restore the cell under the old cursor position
// WR2   | draw the cursor glyph at the new position, then commit it
// CLR   | sweep all cells, one per cycle, index 0 gets the cursor glyph
module console_writer #(
    parameter int GRID_ROW = 5,
    parameter int GRID_COL = 10
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  ascii,
    input  logic [3:0]  colorF,
    input  logic [3:0]  colorB,
    output logic        ready,
    output logic        we,
    output logic [31:0] a,
    output logic [31:0] wd,
    output logic [5:0]  cursor_pos
);

    localparam int N = GRID_ROW * GRID_COL;

    localparam logic [7:0] K_CLEAR = 8'h02;
    localparam logic [7:0] K_ENTER = 8'h0D;
    localparam logic [7:0] K_LEFT  = 8'h11;
    localparam logic [7:0] K_UP    = 8'h12;
    localparam logic [7:0] K_DOWN  = 8'h13;
    localparam logic [7:0] K_RIGHT = 8'h14;
    localparam logic [7:0] K_BKSP  = 8'h7F;
    localparam logic [7:0] GLYPH   = 8'd127;

    typedef enum logic [1:0] {IDLE, WR1, WR2, CLR} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cur;
    logic [5:0]  idx;
    logic [5:0]  p_next;
    logic [7:0]  cmd;
    logic [3:0]  fg, bg;
    logic [15:0] shadow [N];
    logic [15:0] wr1_data;
    logic        accept;
    logic        is_move;

    assign accept     = valid && ready;
    assign cursor_pos = cur;
    assign is_move    = (cmd == K_LEFT) || (cmd == K_RIGHT) || (cmd == K_UP) ||
                        (cmd == K_DOWN) || (cmd == K_ENTER);

    function automatic logic [31:0] cell_addr(input logic [5:0] i);
        return {23'd0, 1'b1, i, 2'b00};
    endfunction

    // State register; reset parks the FSM in the clear sweep.
    always_ff @(posedge clk_pix) begin
        if (rst) state <= CLR;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (ascii == K_CLEAR) ? CLR : WR1;
            WR1:  state_nxt = WR2;
            WR2:  state_nxt = IDLE;
            CLR:  if (idx == 6'(N - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // New cursor position for the latched command, derived from the old one.
    always_comb begin
        p_next = cur;
        case (cmd)
            K_LEFT, K_BKSP: p_next = (cur == 6'd0) ? 6'(N - 1) : cur - 6'd1;
            K_UP:    p_next = (cur < 6'(GRID_COL)) ? cur + 6'(N - GRID_COL)
                                                   : cur - 6'(GRID_COL);
            K_DOWN:  p_next = (cur >= 6'(N - GRID_COL)) ? cur - 6'(N - GRID_COL)
                                                        : cur + 6'(GRID_COL);
            K_ENTER: p_next = (cur >= 6'(N - GRID_COL)) ? 6'd0
                            : 6'((int'(cur) / GRID_COL + 1) * GRID_COL);
            default: p_next = (cur == 6'(N - 1)) ? 6'd0 : cur + 6'd1;
        endcase
    end

    // First write of a command: new character, blank, or restore of the old cell.
    always_comb begin
        if (is_move)            wr1_data = shadow[cur];
        else if (cmd == K_BKSP) wr1_data = {bg, fg, 8'h00};
        else                    wr1_data = {bg, fg, cmd};
    end

    // Command capture, cursor and clear index; colors default to F=5, B=1.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            cur <= 6'd0;
            idx <= 6'd0;
            cmd <= 8'h00;
            fg  <= 4'd5;
            bg  <= 4'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd <= ascii;
                        fg  <= (colorF == 4'd0) ? 4'd5 : colorF;
                        bg  <= (colorB == 4'd0) ? 4'd1 : colorB;
                        idx <= 6'd0;
                    end
                end
                WR2: cur <= p_next;
                CLR: begin
                    cur <= 6'd0;
                    if (idx != 6'(N - 1)) idx <= idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Shadow grid update; holds underlying content only, never the cursor glyph.
    always_ff @(posedge clk_pix) begin
        if (!rst) begin
            if (state == CLR)
                shadow[idx] <= {bg, fg, 8'h00};
            else if (state == WR1 && !is_move)
                shadow[cur] <= wr1_data;
        end
    end

    // Bus outputs; everything quiet while reset is held.
    always_comb begin
        ready = 1'b0;
        we    = 1'b0;
        a     = 32'd0;
        wd    = 32'd0;
        if (!rst) begin
            case (state)
                IDLE: ready = 1'b1;
                WR1: begin
                    we = 1'b1;
                    a  = cell_addr(cur);
                    wd = {16'd0, wr1_data};
                end
                WR2: begin
                    we = 1'b1;
                    a  = cell_addr(p_next);
                    wd = {16'd0, bg, fg, GLYPH};
                end
                CLR: begin
                    we = 1'b1;
                    a  = cell_addr(idx);
                    wd = {16'd0, bg, fg, (idx == 6'd0) ? GLYPH : 8'h00};
                end
                default: ;
            endcase
        end
    end

endmodule
